sfx_sequencer: RTL and testbench

Sound-effect sequencer that sits directly downstream of the game-state FSM. It consumes the FSM's `audioSelect`/`audioEnable` request and plays a fixed four-note square-wave jingle on the speaker pin. While a jingle is playing it holds `seqEnd` low, and the FSM uses `seqEnd` to gate `continue_btn` on the level-up, world-up, win and lose screens.

---
 rtl/sfx_sequencer.sv | 143 ++++++++++++++
 tb/tb_sfx_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sfx_sequencer.sv
// Four-note square-wave jingle player driven by the game FSM's audio request.
// seqEnd is low for exactly 4*(NOTE_TICKS+GAP_TICKS)*TICK_DIV cycles per jingle.
module sfx_sequencer #(
  parameter int TICK_DIV   = 100000,
  parameter int NOTE_TICKS = 120,
  parameter int GAP_TICKS  = 30,
  parameter int BASE_HALF  = 12500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] audioSelect,
  input  logic       audioEnable,
  output logic       audio_out,
  output logic       seqEnd,
  output logic       playing
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DMAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int DW   = (DMAX > 0) ? $clog2(DMAX + 1) : 1;
  localparam int TW   = (7 * BASE_HALF > 1) ? $clog2(7 * BASE_HALF) : 1;

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  state_t        r_state;
  logic [2:0]    r_sel;
  logic [1:0]    r_slot;
  logic [PW-1:0] r_presc;
  logic [DW-1:0] r_dur;
  logic [TW-1:0] r_tone;
  logic          r_audio;
  logic          r_seq_end;
  logic          r_playing;

  logic          w_start;
  logic          w_tick;
  logic          w_note_done;
  logic          w_gap_done;
  logic          w_adv;
  logic [2:0]    w_pitch;
  logic [TW-1:0] w_half_m1;

  function automatic logic [2:0] rom(input logic [2:0] s, input logic [1:0] k);
    logic [11:0] row;
    case (s)
      3'd2:    row = {3'd3, 3'd5, 3'd7, 3'd0};
      3'd3:    row = {3'd1, 3'd3, 3'd5, 3'd7};
      3'd4:    row = {3'd5, 3'd3, 3'd1, 3'd0};
      3'd5:    row = {3'd5, 3'd7, 3'd5, 3'd7};
      3'd6:    row = {3'd4, 3'd3, 3'd2, 3'd1};
      default: row = '0;
    endcase
    case (k)
      2'd0:    return row[11:9];
      2'd1:    return row[8:6];
      2'd2:    return row[5:3];
      default: return row[2:0];
    endcase
  endfunction

  assign w_start     = audioEnable && (audioSelect >= 3'd2) && (audioSelect <= 3'd6);
  assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
  assign w_note_done = w_tick && (r_dur == DW'(NOTE_TICKS - 1));
  assign w_gap_done  = w_tick && (r_dur == DW'(GAP_TICKS - 1));
  assign w_pitch     = rom(r_sel, r_slot);
  // Pitch 0 is a rest, so the out-of-range value this yields for it is never used.
  assign w_half_m1   = TW'(BASE_HALF * (8 - int'(w_pitch)) - 1);
  assign w_adv       = ((r_state == NOTE) && w_note_done && (GAP_TICKS == 0)) ||
                       ((r_state == GAP) && w_gap_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_slot    <= '0;
      r_presc   <= '0;
      r_dur     <= '0;
      r_tone    <= '0;
      r_audio   <= 1'b0;
      r_seq_end <= 1'b1;
      r_playing <= 1'b0;
    end else if (w_start) begin
      // A valid strobe wins over everything, including the completing cycle.
      r_state   <= NOTE;
      r_sel     <= audioSelect;
      r_slot    <= '0;
      r_presc   <= '0;
      r_dur     <= '0;
      r_tone    <= '0;
      r_audio   <= 1'b0;
      r_seq_end <= 1'b0;
      r_playing <= 1'b1;
    end else begin
      case (r_state)
        NOTE: begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
          if (w_note_done) begin
            r_dur   <= '0;
            r_tone  <= '0;
            r_audio <= 1'b0;
            if (GAP_TICKS > 0) r_state <= GAP;
          end else begin
            if (w_tick) r_dur <= r_dur + 1'b1;
            if (w_pitch == 3'd0) begin
              r_tone  <= '0;
              r_audio <= 1'b0;
            end else if (r_tone == w_half_m1) begin
              r_tone  <= '0;
              r_audio <= ~r_audio;
            end else begin
              r_tone <= r_tone + 1'b1;
            end
          end
        end
        GAP: begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
          r_audio <= 1'b0;
          if (w_tick) r_dur <= r_dur + 1'b1;
        end
        default: ;
      endcase

      if (w_adv) begin
        r_dur   <= '0;
        r_tone  <= '0;
        r_audio <= 1'b0;
        if (r_slot == 2'd3) begin
          r_state   <= IDLE;
          r_seq_end <= 1'b1;
          r_playing <= 1'b0;
        end else begin
          r_slot  <= r_slot + 2'd1;
          r_state <= NOTE;
        end
      end
    end
  end

  assign audio_out = r_audio;
  assign seqEnd    = r_seq_end;
  assign playing   = r_playing;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Directed bench: each valid strobe pushes the full expected jingle trace, built
// from the note table and timing formulas, which is then popped one cycle at a time.
module tb_sfx_sequencer;

  localparam int TD   = 4;
  localparam int NT   = 3;
  localparam int GT   = 1;
  localparam int BH   = 2;
  localparam int SLOT = (NT + GT) * TD;
  localparam int SND  = NT * TD;
  localparam int JLEN = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] sel = '0;
  logic       en  = 1'b0;
  logic       audio_out;
  logic       seqEnd;
  logic       playing;

  typedef struct packed {
    logic a;
    logic e;
  } exp_t;

  exp_t  q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    t_idx = 0;
  string tag   = "init";

  always #5 clk = ~clk;

  sfx_sequencer #(
    .TICK_DIV(TD), .NOTE_TICKS(NT), .GAP_TICKS(GT), .BASE_HALF(BH)
  ) dut (
    .clk(clk), .rst(rst), .audioSelect(sel), .audioEnable(en),
    .audio_out(audio_out), .seqEnd(seqEnd), .playing(playing)
  );

  function automatic int pitch(int s, int k);
    logic [11:0] row;
    case (s)
      2:       row = {3'd3, 3'd5, 3'd7, 3'd0};
      3:       row = {3'd1, 3'd3, 3'd5, 3'd7};
      4:       row = {3'd5, 3'd3, 3'd1, 3'd0};
      5:       row = {3'd5, 3'd7, 3'd5, 3'd7};
      6:       row = {3'd4, 3'd3, 3'd2, 3'd1};
      default: row = '0;
    endcase
    return int'(row[11 - 3*k -: 3]);
  endfunction

  // Expected outputs t cycles after the start edge (t >= JLEN means idle).
  function automatic exp_t model(int s, int t);
    exp_t r;
    int k, w, p, h;
    if (t >= JLEN) begin
      r.a = 1'b0;
      r.e = 1'b1;
      return r;
    end
    k = t / SLOT;
    w = t % SLOT;
    p = pitch(s, k);
    r.e = 1'b0;
    if (w >= SND || p == 0) r.a = 1'b0;
    else begin
      h   = BH * (8 - p);
      r.a = ((w / h) % 2) == 1;
    end
    return r;
  endfunction

  task automatic push_jingle(int s);
    q.delete();
    for (int t = 0; t < JLEN; t++) q.push_back(model(s, t));
    t_idx = 0;
  endtask

  task automatic push_idle(int n);
    for (int i = 0; i < n; i++) q.push_back(model(0, JLEN));
  endtask

  task automatic cmp_now();
    exp_t x;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $error("FAIL %s t=%0d scoreboard empty: got output with no expectation", tag, t_idx);
      return;
    end
    x = q.pop_front();
    assert (audio_out === x.a) else begin
      n_bad++;
      $error("FAIL %s t=%0d audio_out got %b want %b", tag, t_idx, audio_out, x.a);
    end
    n_cmp++;
    assert (seqEnd === x.e) else begin
      n_bad++;
      $error("FAIL %s t=%0d seqEnd got %b want %b", tag, t_idx, seqEnd, x.e);
    end
    n_cmp++;
    assert (playing === ~x.e) else begin
      n_bad++;
      $error("FAIL %s t=%0d playing got %b want %b", tag, t_idx, playing, ~x.e);
    end
    t_idx++;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cmp_now();
    end
  endtask

  task automatic strobe(int s);
    sel = 3'(s);
    en  = 1'b1;
    if (s >= 2 && s <= 6) push_jingle(s);
    step(1);
    en  = 1'b0;
    sel = '0;
  endtask

  task automatic async_reset(int hold);
    rst = 1'b0;
    q.delete();
    push_idle(1);
    #1;
    cmp_now();
    push_idle(hold);
    step(hold);
    rst = 1'b1;
    push_idle(8);
    step(8);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    tag = "reset";
    push_idle(1);
    cmp_now();
    rst = 1'b1;
    push_idle(2);
    step(2);

    tag = "sel2";
    strobe(2);
    step(JLEN - 1);
    push_idle(4);
    step(4);

    tag = "sel3";
    strobe(3);
    step(JLEN - 1);
    push_idle(2);
    step(2);

    tag = "inv7_idle";
    push_idle(3);
    strobe(7);
    step(2);

    tag = "inv1_mid";
    strobe(4);
    step(19);
    strobe(1);
    step(JLEN - 21);
    push_idle(2);
    step(2);

    tag = "restart";
    strobe(5);
    step(29);
    strobe(6);
    step(JLEN - 1);
    push_idle(2);
    step(2);

    tag = "complete_restart";
    strobe(2);
    step(JLEN - 1);
    strobe(4);
    step(JLEN - 1);
    push_idle(2);
    step(2);

    tag = "rst_mid";
    strobe(2);
    step(20);
    async_reset(3);

    tag = "rst_tone_high";
    strobe(5);
    step(22);
    async_reset(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
